fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port pc_write_i  input  1  1 = PC may advance, 0 = load-use stall (hold PC and IF/ID).
REQ-005 SHALL have port if_id_flush_i  input  1  1 = replace IF/ID contents with bubble.
REQ-006 SHALL have port mem_pc_select_i  input  1  1 = taken branch resolved in MEM, redirect.
REQ-007 SHALL have port mem_branch_target_i  input  32  redirect target PC.
REQ-008 SHALL have port imem_req_o  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr_o  output  32  fetch address, stable while imem_req_o=1 and imem_ready_i=0.
REQ-010 SHALL have port imem_ready_i  input  1  response valid this cycle; completes the request.
REQ-011 SHALL have port imem_data_i  input  32  instruction word, sampled when imem_ready_i=1.
REQ-012 SHALL have ports id_instr_o  output  32 / id_pc_plus4_o  output  32 / id_valid_o  output  1  IF/ID register contents.

Function
REQ-013 SHALL implement states BOOT, FETCH, DROP, HOLD; imem_req_o=1 only in FETCH and DROP.
REQ-014 SHALL go BOOT->FETCH unconditionally on the first edge after reset release.
REQ-015 SHALL in FETCH drive imem_addr_o=pc; on ready & pc_write_i=1 load IF/ID with {imem_data_i, pc+4, valid=1} and set pc=pc+4 (modulo 2^32).
REQ-016 SHALL in FETCH on ready & pc_write_i=0 store imem_data_i in hold buffer, leave PC and IF/ID unchanged, go HOLD.
REQ-017 SHALL in FETCH on !ready load IF/ID with bubble when pc_write_i=1, hold IF/ID when pc_write_i=0.
REQ-018 SHALL in HOLD, when pc_write_i=1, load IF/ID from hold buffer with pc+4, advance pc, go FETCH; stay HOLD while pc_write_i=0.
REQ-019 SHALL on mem_pc_select_i=1 (any state except BOOT) set pc=mem_branch_target_i, load IF/ID bubble, discard hold buffer, ignore pc_write_i.
REQ-020 SHALL on redirect in FETCH with !ready keep the old address on imem_addr_o, go DROP; redirect with ready discards the response and stays FETCH.
REQ-021 SHALL in DROP hold the old address, discard the response on ready and go FETCH; a further redirect in DROP only updates pc.
REQ-022 SHALL apply if_id_flush_i (absent redirect) as IF/ID bubble with precedence over loads, without changing PC or state transitions.
REQ-023 SHALL define bubble as id_instr_o=32'h0000_0000, id_pc_plus4_o=0, id_valid_o=0.
REQ-024 SHALL apply priority: reset > mem_pc_select_i > if_id_flush_i > pc_write_i.

Reset
REQ-025 SHALL on rst_i=1 immediately set state=BOOT, pc=RESET_PC, IF/ID=bubble, hold buffer=0, imem_req_o=0.
REQ-026 SHALL abandon any outstanding request on reset; a response arriving during BOOT is ignored.

Configuration
REQ-027 SHALL, with FETCH_PERF_CNT_EN defined, add outputs perf_stall_cnt_o (32) counting cycles with pc_write_i=0 and perf_redirect_cnt_o (32) counting redirects, both saturating at 32'hFFFF_FFFF and reset to 0.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, omit those ports and counters with otherwise identical behaviour.

Structure
REQ-029 SHALL place state enum, NOP_INSTR constant and default RESET_PC in shared package fetch_pkg.
REQ-030 SHALL instantiate one sub-module if_id_reg (IF/ID register with load/flush/hold controls).

Verification
REQ-031 SHALL cover reset, ready every cycle: IF/ID shows PC+4 = 4, 8, 12 on successive cycles, id_valid_o=1.
REQ-032 SHALL cover pc_write_i=0 for 2 cycles while ready=1 at pc=0x10: state HOLD, PC stays 0x10, IF/ID unchanged, then resumes with id_pc_plus4_o=0x14.
REQ-033 SHALL cover redirect to 0x100 with ready=0: DROP, imem_addr_o held, late response discarded, next fetch address 0x100.
REQ-034 SHALL cover simultaneous mem_pc_select_i=1 and pc_write_i=0: PC becomes target, IF/ID bubble.
REQ-035 SHALL cover rst_i asserted in DROP: imem_req_o=0 same cycle, restart at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the bubble instruction word and the default boot PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between fetch stage (master) and imem (slave).
// One outstanding request; imem_ready_i completes it, and imem_addr_o stays stable until then.
interface fetch_stage_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_data_i
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold; 1-cycle latency.
// No backpressure of its own; the caller holds it by deasserting load.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else if (load) begin
      id_instr    <= instr;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC/imem FSM feeding IF/ID, 1-cycle from imem_ready_i to IF/ID; stalls via pc_write_i into a hold buffer.
// Optional perf counters (stall cycles, redirects) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pc_write_i,
  input  logic                 if_id_flush_i,
  input  logic                 mem_pc_select_i,
  input  logic [31:0]          mem_branch_target_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          id_instr_o,
  output logic [31:0]          id_pc_plus4_o,
  output logic                 id_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_redirect_cnt_o
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  hold_buf;
  logic [31:0]  addr_q;
  logic         req_q;

  logic         redirect;
  logic         ready;
  logic [31:0]  pc_plus4;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;

  always_comb begin
    ready     = imem.imem_ready_i;
    redirect  = mem_pc_select_i && (state != BOOT);
    pc_plus4  = pc + 32'd4;
    ifid_load = pc_write_i && (((state == FETCH) && ready) || (state == HOLD));
    // Pipeline advancing with nothing fetched (waiting or dropping) inserts a bubble.
    ifid_flush = redirect || if_id_flush_i ||
                 (pc_write_i && (((state == FETCH) && !ready) || (state == DROP)));
    ifid_instr = (state == HOLD) ? hold_buf : imem.imem_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      hold_buf <= 32'd0;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= FETCH;
          req_q  <= 1'b1;
          addr_q <= pc;
        end
        FETCH: begin
          if (redirect) begin
            pc       <= mem_branch_target_i;
            hold_buf <= 32'd0;
            // Without a response the old address must stay on the bus until it completes.
            if (ready) addr_q <= mem_branch_target_i;
            else       state  <= DROP;
          end else if (ready && pc_write_i) begin
            pc     <= pc_plus4;
            addr_q <= pc_plus4;
          end else if (ready) begin
            hold_buf <= imem.imem_data_i;
            state    <= HOLD;
            req_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= mem_branch_target_i;
            hold_buf <= 32'd0;
            addr_q   <= mem_branch_target_i;
            state    <= FETCH;
            req_q    <= 1'b1;
          end else if (pc_write_i) begin
            pc     <= pc_plus4;
            addr_q <= pc_plus4;
            state  <= FETCH;
            req_q  <= 1'b1;
          end
        end
        DROP: begin
          if (redirect) begin
            pc       <= mem_branch_target_i;
            hold_buf <= 32'd0;
          end
          if (ready) begin
            state  <= FETCH;
            addr_q <= redirect ? mem_branch_target_i : pc;
          end
        end
        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr       (ifid_instr),
    .pc_plus4    (pc_plus4),
    .id_instr    (id_instr_o),
    .id_pc_plus4 (id_pc_plus4_o),
    .id_valid    (id_valid_o)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stall_cnt_o    <= 32'd0;
      perf_redirect_cnt_o <= 32'd0;
    end else begin
      if (!pc_write_i && (perf_stall_cnt_o != 32'hFFFF_FFFF))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (redirect && (perf_redirect_cnt_o != 32'hFFFF_FFFF))
        perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, HOLD stall, DROP redirect, redirect+stall, flush, reset in DROP.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        if_id_flush_i;
  logic        mem_pc_select_i;
  logic [31:0] mem_branch_target_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_plus4_o;
  logic        id_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_redirect_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .pc_write_i          (pc_write_i),
    .if_id_flush_i       (if_id_flush_i),
    .mem_pc_select_i     (mem_pc_select_i),
    .mem_branch_target_i (mem_branch_target_i),
    .imem                (imem.master),
    .id_instr_o          (id_instr_o),
    .id_pc_plus4_o       (id_pc_plus4_o),
    .id_valid_o          (id_valid_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt_o    (perf_stall_cnt_o),
    .perf_redirect_cnt_o (perf_redirect_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i               = 1'b1;
    pc_write_i          = 1'b0;
    if_id_flush_i       = 1'b0;
    mem_pc_select_i     = 1'b0;
    mem_branch_target_i = 32'd0;
    imem.imem_ready_i   = 1'b0;
    imem.imem_data_i    = 32'd0;

    repeat (2) tick();
    check("rst_req",   32'(imem.imem_req_o), 32'd0);
    check("rst_valid", 32'(id_valid_o), 32'd0);
    check("rst_pc4",   id_pc_plus4_o, 32'd0);
    check("rst_instr", id_instr_o, 32'd0);

    // BOOT -> FETCH
    rst_i = 1'b0;
    tick();
    check("boot_req",  32'(imem.imem_req_o), 32'd1);
    check("boot_addr", imem.imem_addr_o, 32'd0);

    // Streaming, ready every cycle
    imem.imem_ready_i = 1'b1;
    pc_write_i        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem.imem_data_i = 32'h1000_0000 + 32'(i);
      tick();
      check("strm_pc4",   id_pc_plus4_o, 32'(4 * (i + 1)));
      check("strm_instr", id_instr_o, 32'h1000_0000 + 32'(i));
      check("strm_valid", 32'(id_valid_o), 32'd1);
    end
    check("strm_addr", imem.imem_addr_o, 32'h10);

    // Stall with response at pc=0x10
    pc_write_i       = 1'b0;
    imem.imem_data_i = 32'hCAFE_0010;
    tick();
    check("hold_req",   32'(imem.imem_req_o), 32'd0);
    check("hold_addr",  imem.imem_addr_o, 32'h10);
    check("hold_pc4",   id_pc_plus4_o, 32'h10);
    check("hold_instr", id_instr_o, 32'h1000_0003);
    imem.imem_ready_i = 1'b0;
    tick();
    check("hold2_req",  32'(imem.imem_req_o), 32'd0);
    check("hold2_pc4",  id_pc_plus4_o, 32'h10);
    check("hold2_addr", imem.imem_addr_o, 32'h10);
    pc_write_i = 1'b1;
    tick();
    check("resume_req",   32'(imem.imem_req_o), 32'd1);
    check("resume_pc4",   id_pc_plus4_o, 32'h14);
    check("resume_instr", id_instr_o, 32'hCAFE_0010);
    check("resume_valid", 32'(id_valid_o), 32'd1);
    check("resume_addr",  imem.imem_addr_o, 32'h14);

    // Redirect with outstanding request -> DROP
    mem_pc_select_i     = 1'b1;
    mem_branch_target_i = 32'h100;
    tick();
    mem_pc_select_i = 1'b0;
    check("drop_req",   32'(imem.imem_req_o), 32'd1);
    check("drop_addr",  imem.imem_addr_o, 32'h14);
    check("drop_valid", 32'(id_valid_o), 32'd0);
    tick();
    check("drop2_addr", imem.imem_addr_o, 32'h14);
    imem.imem_ready_i = 1'b1;
    imem.imem_data_i  = 32'hBADB_AD00;
    tick();
    check("late_addr",  imem.imem_addr_o, 32'h100);
    check("late_valid", 32'(id_valid_o), 32'd0);
    check("late_instr", id_instr_o, 32'd0);
    imem.imem_data_i = 32'h0000_0100;
    tick();
    check("tgt_pc4",   id_pc_plus4_o, 32'h104);
    check("tgt_instr", id_instr_o, 32'h0000_0100);
    check("tgt_valid", 32'(id_valid_o), 32'd1);
    check("tgt_addr",  imem.imem_addr_o, 32'h104);

    // Redirect together with stall
    mem_pc_select_i     = 1'b1;
    mem_branch_target_i = 32'h200;
    pc_write_i          = 1'b0;
    imem.imem_data_i    = 32'h0000_0055;
    tick();
    mem_pc_select_i = 1'b0;
    check("rs_addr",  imem.imem_addr_o, 32'h200);
    check("rs_valid", 32'(id_valid_o), 32'd0);
    check("rs_pc4",   id_pc_plus4_o, 32'd0);
    check("rs_req",   32'(imem.imem_req_o), 32'd1);

    // Flush over a load: PC still advances
    if_id_flush_i    = 1'b1;
    pc_write_i       = 1'b1;
    imem.imem_data_i = 32'h0000_0066;
    tick();
    if_id_flush_i = 1'b0;
    check("fl_addr",  imem.imem_addr_o, 32'h204);
    check("fl_valid", 32'(id_valid_o), 32'd0);
    check("fl_instr", id_instr_o, 32'd0);

    // Enter DROP, then reset
    imem.imem_ready_i   = 1'b0;
    mem_pc_select_i     = 1'b1;
    mem_branch_target_i = 32'h300;
    tick();
    mem_pc_select_i = 1'b0;
    check("d3_req",  32'(imem.imem_req_o), 32'd1);
    check("d3_addr", imem.imem_addr_o, 32'h204);
`ifdef FETCH_PERF_CNT_EN
    check("perf_redir", perf_redirect_cnt_o, 32'd3);
`endif
    rst_i = 1'b1;
    #1;
    check("rd_req",   32'(imem.imem_req_o), 32'd0);
    check("rd_valid", 32'(id_valid_o), 32'd0);
    check("rd_addr",  imem.imem_addr_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rd_stall_cnt", perf_stall_cnt_o, 32'd0);
    check("rd_redir_cnt", perf_redirect_cnt_o, 32'd0);
`endif
    tick();
    rst_i             = 1'b0;
    imem.imem_ready_i = 1'b1;
    imem.imem_data_i  = 32'hDEAD_0000;
    tick();
    check("rb_req",   32'(imem.imem_req_o), 32'd1);
    check("rb_addr",  imem.imem_addr_o, 32'd0);
    check("rb_valid", 32'(id_valid_o), 32'd0);
    imem.imem_data_i = 32'h0000_000E;
    tick();
    check("rb_pc4",   id_pc_plus4_o, 32'd4);
    check("rb_instr", id_instr_o, 32'h0000_000E);
    check("rb_valid2", 32'(id_valid_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
